mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-addressed data memory port (adr, d_in, mrd, mwr, d_out; combinational read, posedge write) between two requesters: the instruction-fetch unit (IF, read-only) and the load/store unit (DM, read/write).
- Sequences each access through grant, a programmable wait-state window and a one-cycle acknowledge.
- Flags misaligned word accesses without touching memory.
- Sits between the multi-cycle controller/datapath and the memory.

Parameters:
- WAIT_CYCLES, 2: cycles the memory strobes/address are held per access; legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF read request, held until if_ack
- if_adr  in  AW  IF byte address
- if_rdata  out  DW  IF read data, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse to IF
- if_err  out  1  misaligned IF access, valid while if_ack=1
- dm_req  in  1  DM request, held until dm_ack
- dm_wr  in  1  1=write, 0=read
- dm_adr  in  AW  DM byte address
- dm_wdata  in  DW  DM write data
- dm_rdata  out  DW  DM read data, valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse to DM
- dm_err  out  1  misaligned DM access, valid while dm_ack=1
- mem_adr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_mrd  out  1  memory read enable
- mem_mwr  out  1  memory write enable
- mem_dout  in  DW  memory read data (combinational from mem_adr)
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async): state=IDLE, last_grant=IF, wait counter=0. All outputs 0: acks, errs, rdata, mem_adr, mem_din, mem_mrd, mem_mwr, busy. Reset mid-access abandons it; no ack is issued; strobes drop immediately.
- FSM states: IDLE, ACCESS, ACK. All outputs are registered except busy.
- IDLE:
  - Sample requests each cycle.
  - One requester high: grant it.
  - Both high: grant the one not in last_grant (round-robin). After reset DM wins the first tie.
  - On grant: latch owner, address, dm_wr and dm_wdata; update last_grant.
  - Aligned (adr[1:0]==0): go to ACCESS, counter=WAIT_CYCLES-1.
  - Misaligned: go to ACK with err=1 and rdata=0; no memory strobe.
- ACCESS:
  - mem_adr=latched address.
  - Read: mem_mrd=1 every ACCESS cycle.
  - Write: mem_din=latched wdata every ACCESS cycle; mem_mwr=1 only in the final ACCESS cycle (counter==0), giving exactly one write edge.
  - Counter decrements each cycle. At counter==0: for reads capture mem_dout into the owner's rdata register; go to ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle; err as latched; the non-owner's ack/err stay 0.
  - mem_mrd/mem_mwr=0, mem_adr=0, mem_din=0.
  - Next state IDLE.
- rdata holds its captured value until the next access by the same requester. The non-owner's rdata is unaffected.
- Requester protocol:
  - req and the address/data fields must be stable from assertion through the ack cycle.
  - req must be low in the cycle after ack. If it is high in IDLE, that is a new request.
  - A req arriving while busy waits; it is serviced at the next IDLE.
- Latency: req high in IDLE cycle n gives ACCESS in cycles n+1..n+WAIT_CYCLES and ack in cycle n+WAIT_CYCLES+1. Misaligned: ack in cycle n+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- dm_wr is ignored for IF; IF never writes.
- Outside ACCESS, mem_adr, mem_din and the strobes are 0.

Test Plan:
- Reset, then IF read only: mem word at 100 = 1, if_adr=100, WAIT_CYCLES=2, req in cycle 0 -> mem_mrd=1 and mem_adr=100 in cycles 1-2; if_ack=1 and if_rdata=1 in cycle 3; busy low in cycle 4.
- DM write: dm_wr=1, dm_adr=200, dm_wdata=0xDEADBEEF -> mem_mwr high exactly one cycle (cycle 2); a later DM read of 200 returns 0xDEADBEEF with dm_ack.
- Simultaneous if_req and dm_req first time after reset -> DM served first (dm_ack cycle 3), then IF (if_ack cycle 7). Repeat the tie -> IF served first.
- Misaligned: dm_adr=102 read -> dm_ack and dm_err=1 in cycle 1, dm_rdata=0; mem_mrd and mem_mwr never asserted.
- Reset asserted in cycle 2 of a DM write with WAIT_CYCLES=3 -> mem_mwr never rises; memory word unchanged; all outputs 0 immediately; no ack.
- Continuous IF and DM requests for 20 accesses -> strictly alternating grants; each ack exactly one cycle wide; no cycle with both acks high.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/DM requester handshakes and the shared memory port bundle
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          if_req;
  logic [AW-1:0] if_adr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_err;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_adr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_err;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_din;
  logic          mem_mrd;
  logic          mem_mwr;
  logic [DW-1:0] mem_dout;
  logic          busy;
  modport slave (
    input  if_req, if_adr, dm_req, dm_wr, dm_adr, dm_wdata, mem_dout,
    output if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err, mem_adr, mem_din, mem_mrd, mem_mwr, busy
  );
  modport master (
    output if_req, if_adr, dm_req, dm_wr, dm_adr, dm_wdata, mem_dout,
    input  if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err, mem_adr, mem_din, mem_mrd, mem_mwr, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IF/DM sharing of one memory port with wait states and misalignment flagging
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_n;
  logic owner, owner_n, last, last_n, wr, wr_n, err, err_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] adr, adr_n;
  logic [DW-1:0] wdata, wdata_n, if_rdata_n, dm_rdata_n;
  logic grant_dm;
  // owner/last: 0 = IF, 1 = DM; on a tie the requester not granted last time wins
  assign grant_dm = bus.dm_req && (!bus.if_req || !last);
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n = last;
    wr_n = wr;
    err_n = err;
    cnt_n = cnt;
    adr_n = adr;
    wdata_n = wdata;
    if_rdata_n = bus.if_rdata;
    dm_rdata_n = bus.dm_rdata;
    case (state)
      IDLE: if (bus.if_req || bus.dm_req) begin
        owner_n = grant_dm;
        last_n = grant_dm;
        adr_n = grant_dm ? bus.dm_adr : bus.if_adr;
        wr_n = grant_dm && bus.dm_wr;
        wdata_n = bus.dm_wdata;
        err_n = adr_n[1:0] != 2'b00;
        cnt_n = 4'(WAIT_CYCLES - 1);
        state_n = err_n ? ACK : ACCESS;
        dm_rdata_n = (err_n && grant_dm) ? '0 : dm_rdata_n;
        if_rdata_n = (err_n && !grant_dm) ? '0 : if_rdata_n;
      end
      ACCESS: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_n = ACK;
          cnt_n = 4'd0;
          dm_rdata_n = (!wr && owner) ? bus.mem_dout : dm_rdata_n;
          if_rdata_n = (!wr && !owner) ? bus.mem_dout : if_rdata_n;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next-state view so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b0;
      wr <= 1'b0;
      err <= 1'b0;
      cnt <= 4'd0;
      adr <= '0;
      wdata <= '0;
      bus.if_rdata <= '0;
      bus.dm_rdata <= '0;
      bus.if_ack <= 1'b0;
      bus.if_err <= 1'b0;
      bus.dm_ack <= 1'b0;
      bus.dm_err <= 1'b0;
      bus.mem_adr <= '0;
      bus.mem_din <= '0;
      bus.mem_mrd <= 1'b0;
      bus.mem_mwr <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last <= last_n;
      wr <= wr_n;
      err <= err_n;
      cnt <= cnt_n;
      adr <= adr_n;
      wdata <= wdata_n;
      bus.if_rdata <= if_rdata_n;
      bus.dm_rdata <= dm_rdata_n;
      bus.if_ack <= state_n == ACK && !owner_n;
      bus.if_err <= state_n == ACK && !owner_n && err_n;
      bus.dm_ack <= state_n == ACK && owner_n;
      bus.dm_err <= state_n == ACK && owner_n && err_n;
      bus.mem_adr <= state_n == ACCESS ? adr_n : '0;
      bus.mem_din <= (state_n == ACCESS && wr_n) ? wdata_n : '0;
      bus.mem_mrd <= state_n == ACCESS && !wr_n;
      bus.mem_mwr <= state_n == ACCESS && wr_n && cnt_n == 4'd0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with an ack scoreboard checked by a separate monitor
module tb_mem_port_arbiter;
  localparam int W = 2;
  typedef struct packed {
    logic dm;
    logic err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus();
  mem_port_arbiter #(.WAIT_CYCLES(W), .AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:255];
  assign bus.mem_dout = mem[bus.mem_adr[9:2]];
  int cyc = 0, total = 0, bad = 0, mrd_cnt = 0, mwr_cnt = 0, mwr_cyc = -1;
  logic [31:0] rd_adr = '0;
  exp_t q[$];
  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic dm, input logic err, input logic [31:0] rdata, input int c);
    q.push_back('{dm: dm, err: err, rdata: rdata, cyc: 32'(c)});
  endtask
  task automatic set_if(input logic [31:0] adr);
    bus.if_adr = adr;
    bus.if_req = 1'b1;
  endtask
  task automatic set_dm(input logic wr, input logic [31:0] adr, input logic [31:0] data);
    bus.dm_wr = wr;
    bus.dm_adr = adr;
    bus.dm_wdata = data;
    bus.dm_req = 1'b1;
  endtask
  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && (bus.if_req || bus.dm_req); i++) begin
      @(negedge clk);
      if (bus.if_ack) bus.if_req = 1'b0;
      if (bus.dm_ack) bus.dm_req = 1'b0;
    end
    check("reqs_completed", 96'({bus.if_req, bus.dm_req}), 96'(0));
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask
  task automatic check_idle_outputs(input string name);
    check({name, "_flags"}, 96'({bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err, bus.mem_mrd, bus.mem_mwr, bus.busy}), 96'(0));
    check({name, "_bus"}, {32'(0), bus.mem_adr, bus.mem_din}, 96'(0));
  endtask
  initial begin
    int n, r0, w0, di, ii, dn, in_, acks;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(i);
    mem[25] = 32'd1;
    mem[75] = 32'hA5A5A5A5;
    {bus.if_req, bus.dm_req, bus.dm_wr} = '0;
    {bus.if_adr, bus.dm_adr, bus.dm_wdata} = '0;
    fork
      forever begin
        @(posedge clk);
        if (bus.mem_mwr) begin
          mem[bus.mem_adr[9:2]] = bus.mem_din;
          mwr_cnt++;
          mwr_cyc = cyc;
        end
        if (bus.mem_mrd) begin
          mrd_cnt++;
          rd_adr = bus.mem_adr;
        end
        cyc++;
      end
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (bus.if_ack || bus.dm_ack)) begin
          check("single_ack", 96'(bus.if_ack & bus.dm_ack), 96'(0));
          if (q.size() == 0) check("ack_expected", 96'(q.size()), 96'(1));
          else begin
            e = q.pop_front();
            check("ack", 96'({bus.dm_ack, bus.if_err | bus.dm_err, bus.dm_ack ? bus.dm_rdata : bus.if_rdata, 32'(cyc)}),
                  96'({e.dm, e.err, e.rdata, e.cyc}));
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none
    tick;
    tick;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rdata", {32'(0), bus.if_rdata, bus.dm_rdata}, 96'(0));
    tick;
    rst = 1'b0;
    tick;
    n = cyc;
    r0 = mrd_cnt;
    set_if(32'd100);
    push(1'b0, 1'b0, 32'd1, n + W + 1);
    wait_done(20);
    check("if_mrd_cycles", 96'(mrd_cnt - r0), 96'(W));
    check("if_rd_adr", 96'(rd_adr), 96'(100));
    tick;
    check("busy_after_ack", 96'(bus.busy), 96'(0));
    n = cyc;
    w0 = mwr_cnt;
    set_dm(1'b1, 32'd200, 32'hDEADBEEF);
    push(1'b1, 1'b0, 32'd0, n + W + 1);
    wait_done(20);
    check("wr_mwr_count", 96'(mwr_cnt - w0), 96'(1));
    check("wr_mwr_cycle", 96'(mwr_cyc), 96'(n + 2));
    check("wr_mem", 96'(mem[50]), 96'(32'hDEADBEEF));
    tick;
    n = cyc;
    set_dm(1'b0, 32'd200, 32'd0);
    push(1'b1, 1'b0, 32'hDEADBEEF, n + 3);
    wait_done(20);
    tick;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    n = cyc;
    set_if(32'd100);
    set_dm(1'b0, 32'd200, 32'd0);
    push(1'b1, 1'b0, 32'hDEADBEEF, n + 3);
    push(1'b0, 1'b0, 32'd1, n + 7);
    wait_done(40);
    tick;
    n = cyc;
    set_dm(1'b0, 32'd204, 32'd0);
    push(1'b1, 1'b0, 32'h1033, n + 3);
    wait_done(20);
    tick;
    n = cyc;
    set_if(32'd8);
    set_dm(1'b0, 32'd200, 32'd0);
    push(1'b0, 1'b0, 32'h1002, n + 3);
    push(1'b1, 1'b0, 32'hDEADBEEF, n + 7);
    wait_done(40);
    tick;
    n = cyc;
    r0 = mrd_cnt;
    w0 = mwr_cnt;
    set_dm(1'b0, 32'd102, 32'd0);
    push(1'b1, 1'b1, 32'd0, n + 1);
    wait_done(20);
    tick;
    n = cyc;
    set_if(32'd101);
    push(1'b0, 1'b1, 32'd0, n + 1);
    wait_done(20);
    check("misaligned_no_strobe", 96'({mrd_cnt - r0, mwr_cnt - w0}), 96'(0));
    tick;
    w0 = mwr_cnt;
    set_dm(1'b1, 32'd300, 32'h12345678);
    tick;
    check("wr_in_access", 96'(bus.mem_adr), 96'(300));
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    bus.dm_req = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    tick;
    check("abort_no_mwr", 96'(mwr_cnt - w0), 96'(0));
    check("abort_mem_kept", 96'(mem[75]), 96'(32'hA5A5A5A5));
    n = cyc;
    for (int j = 0; j < 20; j++)
      push(j % 2 == 0, 1'b0, (j % 2 == 0) ? 32'h1000 + 32'(100 + j / 2) : 32'h1000 + 32'(j / 2), n + 3 + 4 * j);
    di = 0;
    ii = 0;
    dn = -10;
    in_ = -10;
    acks = 0;
    for (int t = 0; t < 200 && acks < 20; t++) begin
      if (!bus.dm_req && di < 10 && cyc >= dn + 2) begin
        set_dm(1'b0, 32'(4 * (100 + di)), 32'd0);
        di++;
      end
      if (!bus.if_req && ii < 10 && cyc >= in_ + 2) begin
        set_if(32'(4 * ii));
        ii++;
      end
      @(negedge clk);
      if (bus.dm_ack) begin
        bus.dm_req = 1'b0;
        dn = cyc;
        acks++;
      end
      if (bus.if_ack) begin
        bus.if_req = 1'b0;
        in_ = cyc;
        acks++;
      end
      tick;
    end
    check("stream_acks", 96'(acks), 96'(20));
    tick;
    tick;
    check("scoreboard_drained", 96'(q.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
